// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined slave backed by a 32-bit word RAM: one request at a time,
// WAIT_STATES idle cycles, then a single-cycle ack with byte-lane writes.
module wb_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t                  state_reg, state_next;
    logic [3:0]              count_reg, count_next;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [31:0]             dat_reg;
    logic                    we_reg;
    logic [3:0]              sel_reg;
    logic                    ack_reg;
    logic [31:0]             rdata_reg;
    logic                    accept, commit;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_dat;
    logic                    acc_we;
    logic [3:0]              acc_sel;

    logic [31:0] mem [DEPTH];

    wire unused_adr = ^{wb_adr_i[1:0], wb_adr_i[31:ADDR_WIDTH+2]};

    assign accept     = (state_reg == IDLE) && wb_cyc_i && wb_stb_i;
    assign wb_stall_o = (state_reg != IDLE);
    assign wb_ack_o   = ack_reg;
    assign wb_dat_o   = rdata_reg;

    // With zero wait states the access commits on the acceptance edge, so it
    // must use the live bus rather than the (not yet loaded) latched request.
    assign acc_idx = (state_reg == IDLE) ? wb_adr_i[ADDR_WIDTH+1:2] : idx_reg;
    assign acc_dat = (state_reg == IDLE) ? wb_dat_i : dat_reg;
    assign acc_we  = (state_reg == IDLE) ? wb_we_i  : we_reg;
    assign acc_sel = (state_reg == IDLE) ? wb_sel_i : sel_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESPOND;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count_reg == 4'd0) begin
                    state_next = RESPOND;
                    commit     = 1'b1;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            idx_reg   <= '0;
            dat_reg   <= 32'd0;
            we_reg    <= 1'b0;
            sel_reg   <= 4'd0;
            ack_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ack_reg   <= commit;
            if (accept) begin
                idx_reg <= wb_adr_i[ADDR_WIDTH+1:2];
                dat_reg <= wb_dat_i;
                we_reg  <= wb_we_i;
                sel_reg <= wb_sel_i;
            end
            if (commit && !acc_we)
                rdata_reg <= mem[acc_idx];
        end
    end

    // Memory is never reset; the rst_i gate keeps a held-in-reset bus from writing.
    always_ff @(posedge clk_i) begin
        if (commit && acc_we && rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b])
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_wb_ram_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) driven from a
// vector table plus hand-written back-to-back, abort and reset sequences.
module tb_wb_ram_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_adr, bus_dat;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic        cyc   [3];
    logic        stb   [3];
    logic        ack   [3];
    logic        stall [3];
    logic [31:0] dato  [3];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd [3];
    logic        prev_ack [3];
    int          ws [3];

    always #5 clk = ~clk;

    wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst_n), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
        .wb_dat_o(dato[0]), .wb_we_i(bus_we), .wb_sel_i(bus_sel), .wb_stb_i(stb[0]),
        .wb_cyc_i(cyc[0]), .wb_ack_o(ack[0]), .wb_stall_o(stall[0]));
    wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
        .clk_i(clk), .rst_i(rst_n), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
        .wb_dat_o(dato[1]), .wb_we_i(bus_we), .wb_sel_i(bus_sel), .wb_stb_i(stb[1]),
        .wb_cyc_i(cyc[1]), .wb_ack_o(ack[1]), .wb_stall_o(stall[1]));
    wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst_n), .wb_adr_i(bus_adr), .wb_dat_i(bus_dat),
        .wb_dat_o(dato[2]), .wb_we_i(bus_we), .wb_sel_i(bus_sel), .wb_stb_i(stb[2]),
        .wb_cyc_i(cyc[2]), .wb_ack_o(ack[2]), .wb_stall_o(stall[2]));

    typedef struct {
        int          k;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Every ack must be a one-cycle pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k]) begin
                checks++;
                if (prev_ack[k]) begin
                    errors++;
                    $display("FAIL ack_width[%0d]: got 2+ cycles expected 1", k);
                end
            end
            prev_ack[k] = ack[k];
        end
    end

    task automatic access(input int k, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] e, input string nm);
        int n;
        int stalls;
        bit got;
        logic [31:0] want;
        @(negedge clk);
        bus_adr = a; bus_dat = d; bus_we = we; bus_sel = s;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        chk({nm, "_stall_pre"}, 32'(stall[k]), 32'd0);
        if (!we) sb_q.push_back(e);
        @(negedge clk);
        stb[k] = 1'b0;
        bus_adr = $urandom; bus_dat = $urandom; bus_we = 1'($urandom); bus_sel = 4'($urandom);
        stalls = 0; got = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (stall[k]) stalls++;
            if (ack[k]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_latency"}, 32'(n), 32'(ws[k] + 1));
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(ws[k] + 1));
        if (got) begin
            if (!we) begin
                want = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
                chk({nm, "_rdata"}, dato[k], want);
                last_rd[k] = want;
            end else begin
                chk({nm, "_dat_hold"}, dato[k], last_rd[k]);
            end
        end else if (!we && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        cyc[k] = 1'b0;
        chk({nm, "_after"}, {30'd0, ack[k], stall[k]}, 32'd0);
    endtask

    initial begin
        int acks;
        ws[0] = 0; ws[1] = 1; ws[2] = 3;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; last_rd[k] = 32'd0; prev_ack[k] = 1'b0;
        end
        bus_adr = 0; bus_dat = 0; bus_we = 0; bus_sel = 0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_state[%0d]", k), {dato[k][29:0], ack[k], stall[k]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{1, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        "w1_wr10"};
        vecs[1]  = '{1, 1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, "w1_rd10"};
        vecs[2]  = '{1, 1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        "lane_init"};
        vecs[3]  = '{1, 1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        "lane_wr0101"};
        vecs[4]  = '{1, 1'b0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, "lane_rd"};
        vecs[5]  = '{1, 1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        "sel0_wr"};
        vecs[6]  = '{1, 1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, "sel0_rd"};
        vecs[7]  = '{1, 1'b0, 32'h1010, 32'h0,        4'hF, 32'hDEADBEEF, "alias_rd"};
        vecs[8]  = '{1, 1'b0, 32'h13,   32'h0,        4'hF, 32'hDEADBEEF, "lowbits_rd"};
        vecs[9]  = '{0, 1'b1, 32'h50,   32'h01020304, 4'hF, 32'h0,        "w0_wr50"};
        vecs[10] = '{0, 1'b0, 32'h50,   32'h0,        4'hF, 32'h01020304, "w0_rd50"};
        vecs[11] = '{0, 1'b1, 32'h50,   32'hA0B0C0D0, 4'h8, 32'h0,        "w0_wr_lane3"};
        vecs[12] = '{0, 1'b0, 32'h50,   32'h0,        4'hF, 32'hA0020304, "w0_rd_lane3"};
        vecs[13] = '{2, 1'b1, 32'h40,   32'h0BADCAFE, 4'hF, 32'h0,        "w3_wr40"};
        vecs[14] = '{2, 1'b0, 32'h40,   32'h0,        4'hF, 32'h0BADCAFE, "w3_rd40"};
        vecs[15] = '{2, 1'b1, 32'h44,   32'h55AA55AA, 4'hF, 32'h0,        "w3_wr44"};

        for (int i = 0; i < 16; i++)
            access(vecs[i].k, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp, vecs[i].name);

        // Back-to-back on the 1-wait-state port: second request presented in RESPOND.
        acks = 0;
        @(negedge clk);
        bus_adr = 32'h30; bus_dat = 32'hCAFEF00D; bus_we = 1'b1; bus_sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        chk("b2b_a_stall", 32'(stall[1]), 32'd0);
        @(negedge clk);
        chk("b2b_n1", {30'd0, ack[1], stall[1]}, 32'b01);
        bus_adr = 32'h30; bus_dat = 32'h0; bus_we = 1'b0; bus_sel = 4'hF;
        sb_q.push_back(32'hCAFEF00D);
        @(negedge clk);
        acks += int'(ack[1]);
        chk("b2b_n2_respond_stall", {30'd0, ack[1], stall[1]}, 32'b11);
        @(negedge clk);
        acks += int'(ack[1]);
        chk("b2b_n3_idle", {30'd0, ack[1], stall[1]}, 32'b00);
        @(negedge clk);
        stb[1] = 1'b0;
        acks += int'(ack[1]);
        chk("b2b_n4_b_accepted", {30'd0, ack[1], stall[1]}, 32'b01);
        @(negedge clk);
        acks += int'(ack[1]);
        chk("b2b_n5_ack", {30'd0, ack[1], stall[1]}, 32'b11);
        chk("b2b_rdata", dato[1], (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx);
        last_rd[1] = 32'hCAFEF00D;
        @(negedge clk);
        acks += int'(ack[1]);
        chk("b2b_n6", {30'd0, ack[1], stall[1]}, 32'b00);
        chk("b2b_ack_count", 32'(acks), 32'd2);
        cyc[1] = 1'b0;

        // Abort on the 3-wait-state port after one WAIT cycle.
        @(negedge clk);
        bus_adr = 32'h40; bus_dat = 32'h12345678; bus_we = 1'b1; bus_sel = 4'hF;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        chk("abort_stall_pre", 32'(stall[2]), 32'd0);
        @(negedge clk);
        chk("abort_wait", {30'd0, ack[2], stall[2]}, 32'b01);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        chk("abort_idle", {30'd0, ack[2], stall[2]}, 32'b00);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(ack[2]), 32'd0);
        end
        chk("abort_dat_hold", dato[2], last_rd[2]);
        access(2, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0BADCAFE, "abort_rd40");

        // Asynchronous reset in the middle of a WAIT.
        @(negedge clk);
        bus_adr = 32'h44; bus_we = 1'b0; bus_sel = 4'hF;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(negedge clk);
        stb[2] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {dato[2][29:0], ack[2], stall[2]}, 32'd0);
        @(negedge clk);
        cyc[2] = 1'b0;
        chk("rst_hold", {dato[2][29:0], ack[2], stall[2]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
        access(2, 1'b0, 32'h44, 32'h0, 4'hF, 32'h55AA55AA, "rst_persist_rd44");
        access(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "rst_persist_rd10");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_ram_responder.md
Name: wb_ram_responder

Overview:
Wishbone B4 pipelined slave that serves the load-store unit's data bus from an on-chip 32-bit word memory. It is the responder end of the bus that the load-store master drives. It accepts one request at a time, inserts a configurable number of wait states and returns a single-cycle ack, with read data for reads. It applies byte-lane writes for stores. It is used as the data RAM in the core testbench and in small SoC builds.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory depth is 2**ADDR_WIDTH words of 32 bits.
WAIT_STATES, 1, idle cycles inserted between request acceptance and ack (0..15).

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  asynchronous, active-low reset
wb_adr_i  input  32  byte address; bits [ADDR_WIDTH+1:2] index the memory
wb_dat_i  input  32  store data
wb_dat_o  output  32  load data; valid while wb_ack_o=1 for reads
wb_we_i  input  1  1=write, 0=read
wb_sel_i  input  4  byte-lane enables; bit n covers dat[8n+7:8n]
wb_stb_i  input  1  request strobe
wb_cyc_i  input  1  bus cycle active
wb_ack_o  output  1  single-cycle completion pulse
wb_stall_o  output  1  1=request not accepted this cycle

Behaviour:
- Reset (rst_i=0, asynchronous): wb_ack_o=0, wb_stall_o=0, wb_dat_o=0, state=IDLE, wait counter=0, latched request cleared. Memory contents are not reset and are retained across reset.
- States: IDLE, WAIT, RESPOND.
- wb_stall_o = (state != IDLE). It is a combinational decode of the state register only.
- Accept: in IDLE with wb_cyc_i=1 and wb_stb_i=1, the edge latches adr, dat, we and sel.
  - WAIT_STATES=0: next state is RESPOND.
  - Otherwise: next state is WAIT and the counter is loaded with WAIT_STATES-1.
- wb_stb_i=1 with wb_cyc_i=0 is ignored.
- WAIT: the counter decrements each cycle. When the counter is 0, the next state is RESPOND.
- Entering RESPOND (registered actions on that edge):
  - Read: wb_dat_o <= mem[index].
  - Write: each mem byte lane with sel bit set <= wb_dat_i lane.
  - wb_ack_o <= 1.
- RESPOND: wb_ack_o=1 for exactly this one cycle; the next state is IDLE. On the following cycle wb_ack_o=0 and wb_stall_o=0.
- Latency: acceptance edge to ack-high cycle is WAIT_STATES+1 cycles. The minimum request-to-request period is WAIT_STATES+2 cycles.
- Back-to-back: a request presented in the RESPOND cycle sees stall=1 and is not accepted. It is accepted in the next IDLE cycle.
- wb_dat_o holds its last read value outside ack cycles. A write ack leaves wb_dat_o unchanged.
- sel=0000 write: memory unchanged, ack still returned. A read ignores sel and returns the full word.
- Address bits [1:0] are ignored. Bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo the memory size.
- Abort: wb_cyc_i=0 while in WAIT returns the state to IDLE on the next edge. In that case there is no memory write, no ack, and wb_dat_o is unchanged.
  - wb_cyc_i dropping in the RESPOND cycle has no effect: the access has already completed.
- Reset mid-operation: state returns to IDLE immediately with no ack. A write already committed on an earlier edge persists.
- Read-after-write to the same address returns the new data.

Test Plan:
1. WAIT_STATES=1: write adr=0x10, dat=0xDEADBEEF, sel=1111, then read adr=0x10 -> ack 2 cycles after each acceptance edge; stall=1 for 2 cycles after acceptance; read wb_dat_o=0xDEADBEEF.
2. Byte lanes: word 0x20 holds 0x11223344; write dat=0xAABBCCDD with sel=0101, then read 0x20 -> 0x11BB33DD; a sel=0000 write still acks and leaves the word unchanged.
3. Stall/back-to-back: hold cyc=stb=1 with two queued requests; the second is presented during the RESPOND cycle -> not accepted (stall=1), accepted in the next cycle; exactly two ack pulses, each 1 cycle wide.
4. Abort: WAIT_STATES=3, issue a write of 0x12345678 to 0x40, drop cyc after 1 WAIT cycle -> no ack, stall=0 on the next cycle, read of 0x40 returns the prior contents.
5. Reset: assert rst_i=0 asynchronously mid-WAIT -> ack=0, stall=0, dat_o=0 before the next clock edge; after release, data written before reset reads back intact. Aliasing: with ADDR_WIDTH=10, a read of 0x1010 returns the word at 0x10.
6. WAIT_STATES=0: read -> ack on the cycle immediately after the acceptance edge; stall high for exactly 1 cycle.
